arqt1_nios2_gen2_0_cpu_ocimem_bridge: RTL and testbench
=======================================================

// Module: arqt1_nios2_gen2_0_cpu_ocimem_bridge
// PURPOSE
//  Sysclk-domain consumer of the debug slave's jdo/take_action_ocimem_* strobes. Turns host JTAG
//  debug commands into single-word Avalon-style accesses on the OCI debug memory, then returns
//  MonDReg/monitor_ready/monitor_error to the debug slave for host readback. Sits between the
//  debug slave sysclk stage and the OCI RAM/ROM port.
// PARAMETERS
//  ADDR_W   8    word-address width of mem port; legal 1..17 (field jdo[17 +: ADDR_W])
//  TIMEOUT  255  max consecutive mem_waitrequest cycles before abort; legal 1..65535
// PORTS
//  clk                      in   1       system clock; all logic rising-edge
//  reset_n                  in   1       asynchronous active-low reset
//  jdo                      in   38      debug slave data register (stable while a strobe is high)
//  take_action_ocimem_a     in   1       1-cycle strobe: load address, optional read
//  take_no_action_ocimem_a  in   1       1-cycle strobe: read at current address
//  take_action_ocimem_b     in   1       1-cycle strobe: write jdo[34:3] at current address
//  debugack                 in   1       CPU halted in debug mode; writes allowed only when 1
//  mem_address              out  ADDR_W  word address
//  mem_read / mem_write     out  1       request qualifiers, mutually exclusive
//  mem_writedata            out  32      write data
//  mem_readdata             in   32      read data, valid when mem_read && !mem_waitrequest
//  mem_waitrequest          in   1       stall; request held stable while 1
//  MonDReg                  out  32      last read data / last written data
//  monitor_ready            out  1       1 = last command complete, bridge idle
//  monitor_error            out  1       1 = last command rejected, dropped or timed out
// BEHAVIOUR
//  Reset (async assert, sync deassert): state IDLE, MonAReg=0, MonDReg=0, mem_read=mem_write=0,
//   mem_address=0, mem_writedata=0, monitor_ready=1, monitor_error=0, wait counter=0.
//  Commands accepted only in IDLE; priority ocimem_b > ocimem_a > no_action_a; lower simultaneous
//   strobes are silently dropped. Any strobe outside IDLE: dropped, monitor_error<=1.
//  Acceptance (cycle N): monitor_ready<=0, monitor_error<=0.
//   ocimem_a: MonAReg<=jdo[17 +: ADDR_W]; if jdo[34]: RD at the new address, else complete N+1.
//   no_action_a: RD at MonAReg.   ocimem_b: WR of jdo[34:3] at MonAReg.
//   WR with debugack=0: no bus cycle, monitor_error<=1, monitor_ready<=1 at N+1.
//  FSM IDLE -> RD|WR (request registered, visible at N+1) -> DONE (1 cycle) -> IDLE.
//   RD/WR hold address/data/qualifier while mem_waitrequest=1; completes on first cycle with it 0.
//   RD complete: MonDReg<=mem_readdata. WR complete: MonDReg<=written data.
//   Both: MonAReg<=MonAReg+1 (wraps 2^ADDR_W-1 -> 0), qualifier drops next cycle.
//   Zero-wait access: ready=1 at N+3; each stall cycle adds one.
//  Timeout: wait counter counts stalled cycles; at TIMEOUT consecutive stalls the qualifier drops,
//   MonDReg and MonAReg unchanged, monitor_error<=1, -> DONE. Counter clears on entering RD/WR.
//  DONE: monitor_ready<=1; strobes in DONE count as busy (dropped + error).
//  monitor_error stays sticky until the next accepted command.
//  Reset mid-access drops mem_read/mem_write immediately; no completion reported.
//  debugack falling during WR does not abort an issued write.
// STRUCTURE
//  Shared pkg arqt1_nios2_gen2_0_cpu_oci_pkg: state encodings; jdo field constants
//   (JDO_RD_BIT=34, JDO_ADDR_LSB=17, JDO_WDATA_MSB=34, JDO_WDATA_LSB=3).
//  Sub-module arqt1_nios2_gen2_0_cpu_oci_wait_timer: clear/enable stall counter, timeout pulse at TIMEOUT.
//  Top: FSM, MonAReg/MonDReg, output registers. All outputs registered.
// TESTING
//  1 ocimem_a jdo[24:17]=8'h10, jdo[34]=1, readdata=32'hDEADBEEF, no wait -> mem_read@addr 0x10 at N+1;
//    MonDReg=DEADBEEF, ready=1, error=0 at N+3; MonAReg=0x11.
//  2 debugack=1, ocimem_b jdo[34:3]=32'h12345678 then no_action_a, 3 stall cycles each
//    -> write@0x11, read@0x12; ready at N+6 per cmd; MonAReg=0x13.
//  3 debugack=0, ocimem_b -> no mem_write ever, error=1, ready=1 at N+1; MonAReg unchanged.
//  4 TIMEOUT=4, waitrequest stuck 1 on read -> mem_read drops after 4 stalls, error=1, MonDReg kept;
//    next no_action_a with no wait clears error.
//  5 MonAReg=0xFF, read -> MonAReg wraps to 0x00; strobe issued mid-access -> dropped, error=1.
//  6 ocimem_b+ocimem_a same cycle -> only write issued; reset_n low mid-read -> mem_read=0 same
//    cycle, all outputs at reset values.

Source files
------------

// File: rtl/arqt1_nios2_gen2_0_cpu_oci_pkg.sv
// Shared definitions for the OCI debug-memory bridge: FSM states, command codes
// and the bit positions of fields inside the debug slave's jdo register.
package arqt1_nios2_gen2_0_cpu_oci_pkg;

    localparam int unsigned JDO_W         = 38;
    localparam int unsigned JDO_RD_BIT    = 34;
    localparam int unsigned JDO_ADDR_LSB  = 17;
    localparam int unsigned JDO_WDATA_MSB = 34;
    localparam int unsigned JDO_WDATA_LSB = 3;
    localparam int unsigned WAIT_CNT_W    = 16;

    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StWr,
        StDone
    } ocimem_state_e;

    typedef enum logic [1:0] {
        CmdNone,
        CmdAddr,
        CmdRead,
        CmdWrite
    } ocimem_cmd_e;

    // ocimem_b outranks ocimem_a, which outranks no_action_a.
    function automatic ocimem_cmd_e decode_cmd(input logic act_a, input logic noact_a,
                                               input logic act_b);
        ocimem_cmd_e cmd;
        if (act_b) begin
            cmd = CmdWrite;
        end else if (act_a) begin
            cmd = CmdAddr;
        end else if (noact_a) begin
            cmd = CmdRead;
        end else begin
            cmd = CmdNone;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/arqt1_nios2_gen2_0_cpu_oci_wait_timer.sv
// Stall counter for the bridge: counts consecutive enabled cycles and flags the
// cycle on which the TIMEOUT-th stall is being observed.
module arqt1_nios2_gen2_0_cpu_oci_wait_timer
    import arqt1_nios2_gen2_0_cpu_oci_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam logic [WAIT_CNT_W-1:0] LastStall = WAIT_CNT_W'(TIMEOUT - 1);

    logic [WAIT_CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + WAIT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Combinational so the owner can drop its request on this very edge.
    assign timeout = enable && !clear && (count_q == LastStall);

endmodule

// File: rtl/arqt1_nios2_gen2_0_cpu_ocimem_bridge.sv
// Sysclk-side OCI debug-memory bridge: turns jdo/take_action_ocimem_* strobes into
// single-word memory accesses and reports MonDReg / monitor_ready / monitor_error.
module arqt1_nios2_gen2_0_cpu_ocimem_bridge
    import arqt1_nios2_gen2_0_cpu_oci_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              debugack,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    input  logic              mem_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    ocimem_state_e     state_q, state_d;
    ocimem_cmd_e       cmd;
    logic [ADDR_W-1:0] mon_a_q, mon_a_d;
    logic [31:0]       mon_d_q, mon_d_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              ready_q, ready_d;
    logic              error_q, error_d;
    logic              any_strobe;
    logic              timer_clear;
    logic              timer_en;
    logic              timeout;
    logic [ADDR_W-1:0] jdo_addr;
    logic [31:0]       jdo_wdata;
    logic              unused_jdo;

    assign jdo_addr   = jdo[JDO_ADDR_LSB +: ADDR_W];
    assign jdo_wdata  = jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
    assign unused_jdo = ^{jdo[JDO_W-1:JDO_WDATA_MSB+1], jdo[JDO_WDATA_LSB-1:0]};
    assign any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign cmd        = decode_cmd(take_action_ocimem_a, take_no_action_ocimem_a,
                                   take_action_ocimem_b);

    arqt1_nios2_gen2_0_cpu_oci_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (timer_clear),
        .enable  (timer_en),
        .timeout (timeout)
    );

    always_comb begin
        state_d     = state_q;
        mon_a_d     = mon_a_q;
        mon_d_d     = mon_d_q;
        addr_d      = addr_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        wdata_d     = wdata_q;
        ready_d     = ready_q;
        error_d     = error_q;
        timer_clear = 1'b0;
        timer_en    = 1'b0;

        unique case (state_q)
            StIdle: begin
                timer_clear = 1'b1;
                unique case (cmd)
                    CmdWrite: begin
                        error_d = 1'b0;
                        if (debugack) begin
                            ready_d = 1'b0;
                            wr_d    = 1'b1;
                            addr_d  = mon_a_q;
                            wdata_d = jdo_wdata;
                            state_d = StWr;
                        end else begin
                            // Writes are refused while the CPU runs; report at once.
                            ready_d = 1'b1;
                            error_d = 1'b1;
                        end
                    end
                    CmdAddr: begin
                        error_d = 1'b0;
                        mon_a_d = jdo_addr;
                        if (jdo[JDO_RD_BIT]) begin
                            ready_d = 1'b0;
                            rd_d    = 1'b1;
                            addr_d  = jdo_addr;
                            state_d = StRd;
                        end else begin
                            ready_d = 1'b1;
                        end
                    end
                    CmdRead: begin
                        error_d = 1'b0;
                        ready_d = 1'b0;
                        rd_d    = 1'b1;
                        addr_d  = mon_a_q;
                        state_d = StRd;
                    end
                    default: ;
                endcase
            end
            StRd, StWr: begin
                if (any_strobe) begin
                    error_d = 1'b1;
                end
                timer_en = mem_waitrequest;
                if (!mem_waitrequest) begin
                    mon_d_d = (state_q == StRd) ? mem_readdata : wdata_q;
                    mon_a_d = mon_a_q + ADDR_W'(1);
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = StDone;
                end else if (timeout) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    error_d = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (any_strobe) begin
                    error_d = 1'b1;
                end
                ready_d = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            mon_a_q <= '0;
            mon_d_q <= '0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            ready_q <= 1'b1;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mon_a_q <= mon_a_d;
            mon_d_q <= mon_d_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            error_q <= error_d;
        end
    end

    assign mem_address   = addr_q;
    assign mem_read      = rd_q;
    assign mem_write     = wr_q;
    assign mem_writedata = wdata_q;
    assign MonDReg       = mon_d_q;
    assign monitor_ready = ready_q;
    assign monitor_error = error_q;

endmodule

// File: tb/tb_arqt1_nios2_gen2_0_cpu_ocimem_bridge.sv
// Bench for the OCI debug-memory bridge: directed scenarios plus a randomized
// command stream checked against a command-level model of the bridge.
module tb_arqt1_nios2_gen2_0_cpu_ocimem_bridge;

    localparam int unsigned AW = 8;
    localparam int T = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [37:0]   jdo;
    logic          take_action_ocimem_a;
    logic          take_no_action_ocimem_a;
    logic          take_action_ocimem_b;
    logic          debugack;
    logic [AW-1:0] mem_address;
    logic          mem_read;
    logic          mem_write;
    logic [31:0]   mem_writedata;
    logic [31:0]   mem_readdata;
    logic          mem_waitrequest;
    logic [31:0]   MonDReg;
    logic          monitor_ready;
    logic          monitor_error;

    int n_checks = 0;
    int n_fail = 0;

    // Model: the monitor address and data registers as the host would see them.
    logic [7:0]  m_a;
    logic [31:0] m_d;

    always #5 clk = ~clk;

    arqt1_nios2_gen2_0_cpu_ocimem_bridge #(
        .ADDR_W  (AW),
        .TIMEOUT (T)
    ) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .debugack                (debugack),
        .mem_address             (mem_address),
        .mem_read                (mem_read),
        .mem_write               (mem_write),
        .mem_writedata           (mem_writedata),
        .mem_readdata            (mem_readdata),
        .mem_waitrequest         (mem_waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    // Issues one command (strb = {b, no_action_a, a}) at posedge+1 and plays memory:
    // stalls the first `stalls` request cycles. Returns cycles until ready (-1 = never).
    task automatic run_cmd(input logic [2:0] strb, input logic [37:0] jdo_v, input int stalls,
                           input logic [31:0] rdata, input int inject_cyc, output int lat,
                           output int rd_cyc, output int wr_cyc, output logic [7:0] addr,
                           output logic [31:0] wdata);
        int s;
        s = 0;
        lat = -1;
        rd_cyc = 0;
        wr_cyc = 0;
        addr = '0;
        wdata = '0;
        jdo = jdo_v;
        mem_readdata = rdata;
        mem_waitrequest = 1'b0;
        {take_action_ocimem_b, take_no_action_ocimem_a, take_action_ocimem_a} = strb;
        @(posedge clk);
        #1;
        {take_action_ocimem_b, take_no_action_ocimem_a, take_action_ocimem_a} = 3'b000;
        for (int c = 1; c <= 200; c++) begin
            take_no_action_ocimem_a = (c == inject_cyc);
            if (mem_read || mem_write) begin
                if (mem_read) rd_cyc++;
                if (mem_write) wr_cyc++;
                addr = mem_address;
                wdata = mem_writedata;
                mem_waitrequest = (s < stalls);
                if (s < stalls) s++;
            end else begin
                mem_waitrequest = 1'($urandom_range(0, 1));
            end
            if (monitor_ready) begin
                lat = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        take_no_action_ocimem_a = 1'b0;
        mem_waitrequest = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        debugack = 1'b1;
        mem_readdata = '0;
        mem_waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        m_a = 8'h00;
        m_d = 32'h0;
        n_checks++;
        if ({mem_read, mem_write} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_qual: got %b want 00", {mem_read, mem_write});
        end
        n_checks++;
        if (mem_address !== 8'h00 || mem_writedata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_bus: got addr %h wdata %h want 00 0", mem_address, mem_writedata);
        end
        n_checks++;
        if (MonDReg !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mondreg: got %h want 0", MonDReg);
        end
        n_checks++;
        if ({monitor_ready, monitor_error} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_status: got %b want 10", {monitor_ready, monitor_error});
        end
    endtask

    task automatic test_read_basic();
        logic [37:0] jv;
        int lat, rc, wc;
        logic [7:0] a;
        logic [31:0] wd;
        jv = '0;
        jv[24:17] = 8'h10;
        jv[34] = 1'b1;
        run_cmd(3'b001, jv, 0, 32'hDEADBEEF, -1, lat, rc, wc, a, wd);
        m_a = 8'h11;
        m_d = 32'hDEADBEEF;
        n_checks++;
        if (rc !== 1 || wc !== 0 || a !== 8'h10) begin
            n_fail++;
            $display("FAIL rd_basic_bus: got rd %0d wr %0d addr %h want 1 0 10", rc, wc, a);
        end
        n_checks++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL rd_basic_latency: got %0d want 3", lat);
        end
        n_checks++;
        if (MonDReg !== 32'hDEADBEEF || monitor_error !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_basic_result: got %h err %b want deadbeef 0", MonDReg, monitor_error);
        end
    endtask

    task automatic test_write_then_read();
        logic [37:0] jv;
        int lat, rc, wc;
        logic [7:0] a;
        logic [31:0] wd;
        debugack = 1'b1;
        jv = '0;
        jv[34:3] = 32'h12345678;
        run_cmd(3'b100, jv, 3, 32'h0, -1, lat, rc, wc, a, wd);
        n_checks++;
        if (wc !== 4 || rc !== 0 || a !== 8'h11 || wd !== 32'h12345678 || lat !== 6) begin
            n_fail++;
            $display("FAIL wr_stall: got wr %0d rd %0d addr %h data %h lat %0d want 4 0 11 12345678 6",
                     wc, rc, a, wd, lat);
        end
        n_checks++;
        if (MonDReg !== 32'h12345678) begin
            n_fail++;
            $display("FAIL wr_mondreg: got %h want 12345678", MonDReg);
        end
        run_cmd(3'b010, '0, 3, 32'hCAFEF00D, -1, lat, rc, wc, a, wd);
        n_checks++;
        if (rc !== 4 || a !== 8'h12 || lat !== 6 || MonDReg !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL rd_stall: got rd %0d addr %h lat %0d data %h want 4 12 6 cafef00d",
                     rc, a, lat, MonDReg);
        end
        run_cmd(3'b010, '0, 0, 32'h0BADC0DE, -1, lat, rc, wc, a, wd);
        m_a = 8'h14;
        m_d = 32'h0BADC0DE;
        n_checks++;
        if (a !== 8'h13 || lat !== 3) begin
            n_fail++;
            $display("FAIL rd_autoinc: got addr %h lat %0d want 13 3", a, lat);
        end
    endtask

    task automatic test_write_blocked();
        logic [37:0] jv;
        int lat, rc, wc, late_wr;
        logic [7:0] a;
        logic [31:0] wd;
        debugack = 1'b0;
        jv = '0;
        jv[34:3] = 32'hA5A5A5A5;
        run_cmd(3'b100, jv, 0, 32'h0, -1, lat, rc, wc, a, wd);
        n_checks++;
        if (lat !== 1 || monitor_error !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_blocked_status: got lat %0d err %b want 1 1", lat, monitor_error);
        end
        late_wr = wc;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (mem_write) late_wr++;
        end
        n_checks++;
        if (late_wr !== 0 || MonDReg !== m_d) begin
            n_fail++;
            $display("FAIL wr_blocked_bus: got writes %0d data %h want 0 %h", late_wr, MonDReg, m_d);
        end
        debugack = 1'b1;
        run_cmd(3'b010, '0, 0, 32'h11112222, -1, lat, rc, wc, a, wd);
        n_checks++;
        if (a !== m_a || monitor_error !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_blocked_addr: got addr %h err %b want %h 0", a, monitor_error, m_a);
        end
        m_a = m_a + 8'h1;
        m_d = 32'h11112222;
    endtask

    task automatic test_timeout();
        int lat, rc, wc;
        logic [7:0] a;
        logic [31:0] wd;
        run_cmd(3'b010, '0, 50, 32'hFFFF0000, -1, lat, rc, wc, a, wd);
        n_checks++;
        if (rc !== T || lat !== T + 2) begin
            n_fail++;
            $display("FAIL timeout_cycles: got rd %0d lat %0d want %0d %0d", rc, lat, T, T + 2);
        end
        n_checks++;
        if (monitor_error !== 1'b1 || MonDReg !== m_d) begin
            n_fail++;
            $display("FAIL timeout_result: got err %b data %h want 1 %h", monitor_error, MonDReg, m_d);
        end
        run_cmd(3'b010, '0, 0, 32'h76543210, -1, lat, rc, wc, a, wd);
        n_checks++;
        if (monitor_error !== 1'b0 || a !== m_a || MonDReg !== 32'h76543210) begin
            n_fail++;
            $display("FAIL timeout_recover: got err %b addr %h data %h want 0 %h 76543210",
                     monitor_error, a, MonDReg, m_a);
        end
        m_a = m_a + 8'h1;
        m_d = 32'h76543210;
    endtask

    task automatic test_wrap_and_busy();
        logic [37:0] jv;
        int lat, rc, wc;
        logic [7:0] a;
        logic [31:0] wd;
        jv = '0;
        jv[24:17] = 8'hFF;
        jv[34] = 1'b1;
        run_cmd(3'b001, jv, 0, 32'h000000FF, -1, lat, rc, wc, a, wd);
        run_cmd(3'b010, '0, 3, 32'h00000100, 2, lat, rc, wc, a, wd);
        n_checks++;
        if (a !== 8'h00) begin
            n_fail++;
            $display("FAIL wrap_addr: got %h want 00", a);
        end
        n_checks++;
        if (monitor_error !== 1'b1 || lat !== 6 || MonDReg !== 32'h00000100) begin
            n_fail++;
            $display("FAIL busy_strobe: got err %b lat %0d data %h want 1 6 00000100",
                     monitor_error, lat, MonDReg);
        end
        m_a = 8'h01;
        m_d = 32'h00000100;
    endtask

    task automatic test_priority_and_reset();
        logic [37:0] jv;
        int lat, rc, wc;
        logic [7:0] a;
        logic [31:0] wd;
        debugack = 1'b1;
        jv = '0;
        jv[34:3] = 32'h5A5AC3C3;
        jv[24:17] = m_a + 8'h40;
        jv[34] = 1'b1;
        run_cmd(3'b101, jv, 0, 32'h0, -1, lat, rc, wc, a, wd);
        n_checks++;
        if (wc !== 1 || rc !== 0 || a !== m_a || wd !== jv[34:3]) begin
            n_fail++;
            $display("FAIL prio_b_over_a: got wr %0d rd %0d addr %h data %h want 1 0 %h %h",
                     wc, rc, a, wd, m_a, jv[34:3]);
        end
        m_a = m_a + 8'h1;
        m_d = jv[34:3];
        // Start a stalled read, then pull reset mid-access.
        jdo = '0;
        take_no_action_ocimem_a = 1'b1;
        @(posedge clk);
        #1;
        take_no_action_ocimem_a = 1'b0;
        mem_waitrequest = 1'b1;
        n_checks++;
        if (mem_read !== 1'b1 || mem_address !== m_a) begin
            n_fail++;
            $display("FAIL prio_addr_kept: got rd %b addr %h want 1 %h", mem_read, mem_address, m_a);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({mem_read, mem_write, monitor_ready, monitor_error} !== 4'b0010 ||
            MonDReg !== 32'h0 || mem_address !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid_read: got qual %b status %b data %h addr %h want 00 10 0 00",
                     {mem_read, mem_write}, {monitor_ready, monitor_error}, MonDReg, mem_address);
        end
        #3;
        reset_n = 1'b1;
        mem_waitrequest = 1'b0;
        @(posedge clk);
        #1;
        m_a = 8'h00;
        m_d = 32'h0;
    endtask

    task automatic test_random();
        logic [2:0] strb;
        logic [37:0] jv;
        int stalls, lat, rc, wc, exp_lat, exp_rc, exp_wc;
        logic [7:0] a, exp_a;
        logic [31:0] wd, rdata, exp_wd;
        logic exp_err, bus, is_wr, tmo;
        for (int i = 0; i < 60; i++) begin
            strb = 3'($urandom_range(1, 7));
            jv = 38'({$urandom(), $urandom()});
            stalls = $urandom_range(0, 5);
            debugack = 1'($urandom_range(0, 1));
            rdata = $urandom();
            bus = 1'b0;
            is_wr = 1'b0;
            exp_a = m_a;
            exp_wd = jv[34:3];
            if (strb[2]) begin
                bus = debugack;
                is_wr = 1'b1;
            end else if (strb[0]) begin
                m_a = jv[24:17];
                exp_a = m_a;
                bus = jv[34];
            end else begin
                bus = 1'b1;
            end
            tmo = bus && (stalls >= T);
            exp_err = tmo || (is_wr && !debugack);
            exp_lat = !bus ? 1 : (tmo ? T + 2 : stalls + 3);
            exp_rc = (bus && !is_wr) ? (tmo ? T : stalls + 1) : 0;
            exp_wc = (bus && is_wr) ? (tmo ? T : stalls + 1) : 0;
            if (bus && !tmo) begin
                m_d = is_wr ? exp_wd : rdata;
                m_a = m_a + 8'h1;
            end
            run_cmd(strb, jv, stalls, rdata, -1, lat, rc, wc, a, wd);
            n_checks++;
            if (lat !== exp_lat || rc !== exp_rc || wc !== exp_wc) begin
                n_fail++;
                $display("FAIL rand_%0d_timing: got lat %0d rd %0d wr %0d want %0d %0d %0d",
                         i, lat, rc, wc, exp_lat, exp_rc, exp_wc);
            end
            if (bus) begin
                n_checks++;
                if (a !== exp_a || (is_wr && wd !== exp_wd)) begin
                    n_fail++;
                    $display("FAIL rand_%0d_bus: got addr %h data %h want %h %h",
                             i, a, wd, exp_a, exp_wd);
                end
            end
            n_checks++;
            if (MonDReg !== m_d || monitor_error !== exp_err) begin
                n_fail++;
                $display("FAIL rand_%0d_result: got data %h err %b want %h %b",
                         i, MonDReg, monitor_error, m_d, exp_err);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read_basic();
        test_write_then_read();
        test_write_blocked();
        test_timeout();
        test_wrap_and_busy();
        test_priority_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
